// File: rtl/edge_detect_pkg.sv
// Shared constants and debug decode types for the edge detector and its benches.
package edge_detect_pkg;

   localparam int MAX_SYNC_STAGES = 4;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_POS  = 2'd1,
      EDGE_NEG  = 2'd2
   } edge_kind_e;

   function automatic edge_kind_e edge_decode(input logic pos, input logic neg);
      if (pos)
         return EDGE_POS;
      else if (neg)
         return EDGE_NEG;
      else
         return EDGE_NONE;
   endfunction

endpackage

// File: rtl/edge_detector_sync_chain.sv
// N-stage flop chain with synchronous active-low clear; N=0 degenerates to a wire.
module sync_chain
   import edge_detect_pkg::*;
#(
   parameter int N     = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (N == 0) begin : g_bypass
         logic w_unused_ok;
         assign w_unused_ok = clk ^ rst_n;
         assign dout        = din;
      end else begin : g_chain
         logic [WIDTH-1:0] r_stage [N];

         always_ff @(posedge clk) begin
            if (!rst_n)
               r_stage[0] <= '0;
            else
               r_stage[0] <= din;
         end

         for (genvar gi = 1; gi < N; gi++) begin : g_stage
            always_ff @(posedge clk) begin
               if (!rst_n)
                  r_stage[gi] <= '0;
               else
                  r_stage[gi] <= r_stage[gi-1];
            end
         end

         assign dout = r_stage[N-1];
      end
   endgenerate

endmodule

// File: rtl/edge_detector.sv
// Multi-lane level-to-strobe converter: optional synchronizer, sample/history flops,
// and registered-only decode of rising, falling and any-direction edges.
module edge_detector
   import edge_detect_pkg::*;
#(
   parameter int SYNC_STAGES = 0,
   parameter int WIDTH       = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] pos_edge,
   output logic [WIDTH-1:0] neg_edge,
   output logic [WIDTH-1:0] bi_edge
);

   generate
      if (SYNC_STAGES > MAX_SYNC_STAGES || SYNC_STAGES < 0 || WIDTH < 1) begin : g_bad_params
         $error("edge_detector: SYNC_STAGES must be 0..%0d and WIDTH >= 1", MAX_SYNC_STAGES);
      end
   endgenerate

   logic [WIDTH-1:0] w_synced;
   logic [WIDTH-1:0] r_cur;
   logic [WIDTH-1:0] r_prv;

   sync_chain #(
      .N     (SYNC_STAGES),
      .WIDTH (WIDTH)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .dout  (w_synced)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cur <= '0;
         r_prv <= '0;
      end else begin
         r_cur <= w_synced;
         r_prv <= r_cur;
      end
   end

   // Decode uses flop outputs only, so strobes cannot glitch on din activity.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
         assign pos_edge[gi] =  r_cur[gi] & ~r_prv[gi];
         assign neg_edge[gi] = ~r_cur[gi] &  r_prv[gi];
         assign bi_edge[gi]  =  r_cur[gi] ^  r_prv[gi];
      end
   endgenerate

endmodule

// File: tb/tb_edge_detector.sv
// Bench for edge_detector: a 1-lane unsynchronized instance and a 4-lane 2-stage instance,
// checked against a history-based model of what each output must be after every clock edge.
module tb_edge_detector;
   import edge_detect_pkg::*;

   logic       clk = 0;
   logic       rst_n;
   logic       din0;
   logic [3:0] din2;
   logic       pos0, neg0, bi0;
   logic [3:0] pos2, neg2, bi2;

   int total = 0;
   int bad   = 0;

   // History of what was presented at every rising edge: {din2, din0} and rst_n.
   logic [4:0] din_h [0:4095];
   bit         rst_h [0:4095];
   int         n = -1;

   always #5 clk = ~clk;

   edge_detector #(.SYNC_STAGES(0), .WIDTH(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din0),
      .pos_edge(pos0), .neg_edge(neg0), .bi_edge(bi0)
   );

   edge_detector #(.SYNC_STAGES(2), .WIDTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .din(din2),
      .pos_edge(pos2), .neg_edge(neg2), .bi_edge(bi2)
   );

   // Sampled value seen after edge k: din from s edges earlier, provided no reset
   // occurred at any edge in that window (reset wipes the whole pipeline).
   function automatic logic [4:0] sampled_after(int k, int s);
      if (k < s) return '0;
      for (int j = 0; j <= s; j++)
         if (!rst_h[k-j]) return '0;
      return din_h[k-s];
   endfunction

   // Expected {pos2, neg2, bi2, pos0, neg0, bi0} after edge k.
   function automatic logic [14:0] exp_outs(int k);
      logic [4:0] c0, p0, c2, p2;
      logic       a, b;
      logic [3:0] x, y;
      c0 = sampled_after(k, 0);
      c2 = sampled_after(k, 2);
      p0 = (k < 1 || !rst_h[k]) ? 5'd0 : sampled_after(k-1, 0);
      p2 = (k < 1 || !rst_h[k]) ? 5'd0 : sampled_after(k-1, 2);
      a = c0[0]; b = p0[0];
      x = c2[4:1]; y = p2[4:1];
      return {x & ~y, ~x & y, x ^ y, a & ~b, ~a & b, a ^ b};
   endfunction

   task automatic step();
      @(posedge clk);
      n++;
      din_h[n] = {din2, din0};
      rst_h[n] = rst_n;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; din0 = 0; din2 = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) rst_n = 1;
         step();
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== 15'd0) begin
            bad++;
            $display("FAIL reset_quiet n=%0d got=%h exp=0", n, {pos2, neg2, bi2, pos0, neg0, bi0});
         end
      end
   endtask

   task automatic test_single_rise();
      int pc = 0, nc = 0;
      din0 = 1; din2 = 4'h0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== exp_outs(n)) begin
            bad++;
            $display("FAIL single_rise n=%0d got=%h exp=%h", n, {pos2, neg2, bi2, pos0, neg0, bi0}, exp_outs(n));
         end
         total++;
         if (i == 0 && {pos0, bi0} !== 2'b11) begin
            bad++;
            $display("FAIL single_rise_lat n=%0d got=%b exp=11", n, {pos0, bi0});
         end
         pc += pos0; nc += neg0;
      end
      total++;
      if (pc != 1 || nc != 0) begin
         bad++;
         $display("FAIL single_rise_count got pos=%0d neg=%0d exp pos=1 neg=0", pc, nc);
      end
      din0 = 0;
      step(); step();
   endtask

   task automatic test_pattern();
      logic [17:0] pat;
      int pc = 0, nc = 0, bc = 0;
      pat = 18'b000111100100100101;  // LSB first: 1,0,1,0,0,1,0,0,1,0,0,1,1,1,1,0,0,0
      for (int i = 0; i < 18; i++) begin
         din0 = pat[i];
         din2 = 4'($urandom);
         step();
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== exp_outs(n)) begin
            bad++;
            $display("FAIL pattern n=%0d got=%h exp=%h", n, {pos2, neg2, bi2, pos0, neg0, bi0}, exp_outs(n));
         end
         pc += pos0; nc += neg0; bc += bi0;
      end
      total++;
      if (pc != 5 || nc != 5 || bc != 10) begin
         bad++;
         $display("FAIL pattern_count got pos=%0d neg=%0d bi=%0d exp 5/5/10", pc, nc, bc);
      end
   endtask

   task automatic test_toggle();
      int run = 0;
      edge_kind_e last = EDGE_NONE;
      edge_kind_e k;
      din0 = 0; din2 = 4'h0;
      step();
      for (int i = 0; i < 8; i++) begin
         din0 = ~din0;
         din2 = ~din2;
         step();
         k = edge_decode(pos0, neg0);
         total++;
         if (bi0 !== 1'b1 || k == last || k == EDGE_NONE) begin
            bad++;
            $display("FAIL toggle n=%0d got bi=%b kind=%s prev=%s", n, bi0, k.name(), last.name());
         end
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== exp_outs(n)) begin
            bad++;
            $display("FAIL toggle_model n=%0d got=%h exp=%h", n, {pos2, neg2, bi2, pos0, neg0, bi0}, exp_outs(n));
         end
         run += bi0;
         last = k;
      end
      total++;
      if (run != 8) begin
         bad++;
         $display("FAIL toggle_run got=%0d exp=8", run);
      end
   endtask

   task automatic test_reset_high();
      int pc0 = 0;
      int pc2 [4] = '{0, 0, 0, 0};
      rst_n = 0; din0 = 1; din2 = 4'hF;
      step(); step();
      rst_n = 1;
      for (int i = 0; i < 7; i++) begin
         step();
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== exp_outs(n)) begin
            bad++;
            $display("FAIL reset_high n=%0d got=%h exp=%h", n, {pos2, neg2, bi2, pos0, neg0, bi0}, exp_outs(n));
         end
         total++;
         if (pos0 !== (i == 0)) begin
            bad++;
            $display("FAIL reset_high_lat n=%0d got=%b exp=%b", n, pos0, (i == 0));
         end
         pc0 += pos0;
         for (int l = 0; l < 4; l++) pc2[l] += pos2[l];
      end
      total++;
      if (pc0 != 1 || pc2[0] != 1 || pc2[1] != 1 || pc2[2] != 1 || pc2[3] != 1) begin
         bad++;
         $display("FAIL reset_high_count got %0d %0d %0d %0d %0d exp all 1", pc0, pc2[0], pc2[1], pc2[2], pc2[3]);
      end
   endtask

   task automatic test_reset_pulse();
      logic [5:0] d;
      logic [5:0] r;
      d = 6'b010101;  // LSB first: 1,0,1,0,1,0
      r = 6'b111011;  // reset at the third sample
      for (int i = 0; i < 6; i++) begin
         din0 = d[i]; din2 = {4{d[i]}};
         rst_n = r[i];
         step();
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== exp_outs(n)) begin
            bad++;
            $display("FAIL reset_pulse n=%0d got=%h exp=%h", n, {pos2, neg2, bi2, pos0, neg0, bi0}, exp_outs(n));
         end
         if (i == 2 || i == 3) begin
            total++;
            if ({pos2, neg2, bi2, pos0, neg0, bi0} !== 15'd0) begin
               bad++;
               $display("FAIL reset_pulse_quiet n=%0d got=%h exp=0", n, {pos2, neg2, bi2, pos0, neg0, bi0});
            end
         end
      end
      rst_n = 1;
   endtask

   task automatic test_lanes();
      din0 = 0; din2 = 4'h0;
      step(); step(); step(); step();
      // Lane l rises at sample l and stays high; its pulse must appear after sample l+2.
      for (int t = 0; t < 8; t++) begin
         for (int l = 0; l < 4; l++)
            if (t == l) din2[l] = 1'b1;
         step();
         total++;
         for (int l = 0; l < 4; l++) begin
            if (pos2[l] !== (t == l + 2) || neg2[l] !== 1'b0) begin
               bad++;
               $display("FAIL lanes n=%0d lane=%0d got pos=%b neg=%b exp pos=%b neg=0",
                        n, l, pos2[l], neg2[l], (t == l + 2));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         din0  = 1'($urandom);
         din2  = 4'($urandom);
         rst_n = ($urandom_range(0, 31) != 0);
         step();
         total++;
         if ({pos2, neg2, bi2, pos0, neg0, bi0} !== exp_outs(n)) begin
            bad++;
            $display("FAIL random n=%0d got=%h exp=%h", n, {pos2, neg2, bi2, pos0, neg0, bi0}, exp_outs(n));
         end
         total++;
         if ((pos2 & neg2) !== 4'h0 || bi2 !== (pos2 | neg2) || (pos0 & neg0) !== 1'b0 || bi0 !== (pos0 | neg0)) begin
            bad++;
            $display("FAIL random_invariant n=%0d got pos=%h neg=%h bi=%h", n, {pos2, pos0}, {neg2, neg0}, {bi2, bi0});
         end
      end
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; din0 = 0; din2 = 4'h0;
      test_reset();
      test_single_rise();
      test_pattern();
      test_toggle();
      test_reset_high();
      test_reset_pulse();
      test_lanes();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
